// File: rtl/regfl_wr_arb.sv
// Round-robin write-port arbiter feeding the regfl write port.
// Ports: clk, rst_b, req/idx/dat in, [lock], gnt, we/s/d/owner out.
// Optional burst lock: define REGFL_ARB_LOCK_EN to add the lock port.
module regfl_wr_arb #(
  parameter int N  = 4,
  parameter int W  = 64,
  parameter int AW = 3
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [N-1:0]           req,
  input  logic [N*AW-1:0]        idx,
  input  logic [N*W-1:0]         dat,
`ifdef REGFL_ARB_LOCK_EN
  input  logic [N-1:0]           lock,
`endif
  output logic [N-1:0]           gnt,
  output logic                   we,
  output logic [AW-1:0]          s,
  output logic [W-1:0]           d,
  output logic [$clog2(N)-1:0]   owner
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [PW-1:0] nxt;
  logic [PW-1:0] j;
  logic          hit;
  int            jj;

`ifdef REGFL_ARB_LOCK_EN
  logic          locked;
  logic [2:0]    beat;
`endif

  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    hit = 1'b0;
    sel = ptr;
    jj  = 0;
    j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      jj = (int'(ptr) + k) % N;
      j  = PW'(jj);
      if (req[j]) begin
        hit = 1'b1;
        sel = j;
      end
    end
`ifdef REGFL_ARB_LOCK_EN
    // While locked, ptr holds the burst owner.
    if (locked) begin
      hit = req[ptr];
      sel = ptr;
    end
`endif
    gnt = '0;
    if (hit && rst_b) gnt[sel] = 1'b1;
  end

  assign nxt = (sel == PW'(N - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr   <= '0;
      we    <= 1'b0;
      s     <= '0;
      d     <= '0;
      owner <= '0;
`ifdef REGFL_ARB_LOCK_EN
      locked <= 1'b0;
      beat   <= '0;
`endif
    end else if (hit) begin
      we    <= 1'b1;
      s     <= idx[sel*AW +: AW];
      d     <= dat[sel*W +: W];
      owner <= sel;
      ptr   <= nxt;
`ifdef REGFL_ARB_LOCK_EN
      if (!locked) begin
        if (lock[sel]) begin
          locked <= 1'b1;
          beat   <= 3'd1;
          ptr    <= sel;
        end
      end else if (lock[sel] && beat != 3'd7) begin
        beat <= beat + 3'd1;
        ptr  <= sel;
      end else begin
        // Lock dropped or 8th beat: re-arbitrate.
        locked <= 1'b0;
        beat   <= '0;
      end
`endif
    end else begin
      we <= 1'b0;
`ifdef REGFL_ARB_LOCK_EN
      // Owner let req fall: release the lock.
      if (locked) begin
        locked <= 1'b0;
        beat   <= '0;
        ptr    <= nxt;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfl_wr_arb.sv
// Directed testbench for regfl_wr_arb.
// Includes a small regfl model fed by we/s/d.
module tb_regfl_wr_arb;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int AW = 3;

  logic            clk;
  logic            rst_b;
  logic [N-1:0]    req;
  logic [N*AW-1:0] idx;
  logic [N*W-1:0]  dat;
  logic [N-1:0]    gnt;
  logic            we;
  logic [AW-1:0]   s;
  logic [W-1:0]    d;
  logic [1:0]      owner;
`ifdef REGFL_ARB_LOCK_EN
  logic [N-1:0]    lock;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem [8];

  regfl_wr_arb #(.N(N), .W(W), .AW(AW)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .req   (req),
    .idx   (idx),
    .dat   (dat),
`ifdef REGFL_ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .we    (we),
    .s     (s),
    .d     (d),
    .owner (owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (we) begin
      mem[s] <= d;
    end
  end

  task automatic set_rq(input int i,
                        input logic [AW-1:0] ix,
                        input logic [W-1:0] dt);
    idx[i*AW +: AW] = ix;
    dat[i*W +: W]   = dt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = '0;
`ifdef REGFL_ARB_LOCK_EN
    lock  = '0;
`endif
    rst_b = 1'b0;
    #2;
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    req   = 4'b1111;
    idx   = '0;
    dat   = '0;
`ifdef REGFL_ARB_LOCK_EN
    lock  = '0;
`endif
    #1 rst_b = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL rst_gnt got %b exp 0000", gnt);
    end
    checks++;
    if ({we, s, d, owner} !== '0) begin
      errors++;
      $display("FAIL rst_out we=%b s=%0d d=%h owner=%0d exp 0",
               we, s, d, owner);
    end
    req = '0;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_rq(1, 3'd5, 64'hDEAD_BEEF_0000_0001);
    req = 4'b0010;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL single_gnt got %b exp 0010", gnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (we !== 1'b1 || s !== 3'd5 ||
        d !== 64'hDEAD_BEEF_0000_0001 || owner !== 2'd1) begin
      errors++;
      $display("FAIL single_out we=%b s=%0d d=%h owner=%0d",
               we, s, d, owner);
    end
    @(negedge clk);
    req = '0;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL idle_gnt got %b exp 0000", gnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem[5] !== 64'hDEAD_BEEF_0000_0001) begin
      errors++;
      $display("FAIL single_commit got %h exp deadbeef00000001",
               mem[5]);
    end
    checks++;
    if (we !== 1'b0 || s !== 3'd5 ||
        d !== 64'hDEAD_BEEF_0000_0001 || owner !== 2'd1) begin
      errors++;
      $display("FAIL idle_hold we=%b s=%0d d=%h owner=%0d",
               we, s, d, owner);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg;
    do_reset();
    for (int i = 0; i < N; i++)
      set_rq(i, AW'(i + 1), 64'(100 + i));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req = 4'b1111;
      eg = '0;
      eg[k % N] = 1'b1;
      #1;
      checks++;
      if (gnt !== eg) begin
        errors++;
        $display("FAIL rr_gnt%0d got %b exp %b", k, gnt, eg);
      end
      @(posedge clk);
      #1;
      checks++;
      if (we !== 1'b1 || owner !== 2'(k % N) ||
          s !== AW'(k % N + 1) || d !== 64'(100 + k % N)) begin
        errors++;
        $display("FAIL rr_out%0d we=%b owner=%0d s=%0d d=%0d",
                 k, we, owner, s, d);
      end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    req = 4'b0001;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_g0 got %b exp 0001", gnt);
    end
    @(negedge clk);
    req = 4'b1001;
    #1;
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_g3 got %b exp 1000", gnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_g0b got %b exp 0001", gnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (owner !== 2'd0 || we !== 1'b1) begin
      errors++;
      $display("FAIL wrap_owner got %0d/%b exp 0/1", owner, we);
    end
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req = 4'b1111;
    @(posedge clk);
    #1;
    checks++;
    if (we !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_we got %b exp 1", we);
    end
    rst_b = 1'b0;
    #1;
    checks++;
    if (we !== 1'b0 || s !== '0 || d !== '0 || gnt !== '0) begin
      errors++;
      $display("FAIL mid_rst we=%b s=%0d d=%h gnt=%b exp 0",
               we, s, d, gnt);
    end
    rst_b = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL mid_prio got %b exp 0001", gnt);
    end
    @(negedge clk);
    req = '0;
  endtask

`ifdef REGFL_ARB_LOCK_EN
  task automatic test_lock();
    logic [8*W-1:0] q;
    logic [8*W-1:0] eq;
    do_reset();
    eq = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req[2]  = 1'b1;
      lock[2] = 1'b1;
      set_rq(2, AW'(k), 64'hB000_0000 + 64'(k));
      eq[k*W +: W] = 64'hB000_0000 + 64'(k);
      if (k == 1) begin
        req[0] = 1'b1;
        set_rq(0, 3'd6, 64'hAAAA);
      end
      #1;
      checks++;
      if (gnt !== 4'b0100) begin
        errors++;
        $display("FAIL lock_gnt%0d got %b exp 0100", k, gnt);
      end
      @(posedge clk);
      #1;
      checks++;
      if (we !== 1'b1 || s !== AW'(k)) begin
        errors++;
        $display("FAIL lock_s%0d we=%b s=%0d exp 1/%0d",
                 k, we, s, k);
      end
    end
    @(negedge clk);
    set_rq(2, 3'd0, 64'h1234);
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL lock_rel got %b exp 0001", gnt);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) q[i*W +: W] = mem[i];
    checks++;
    if (q !== eq) begin
      errors++;
      $display("FAIL lock_burst q=%h exp %h", q, eq);
    end
    checks++;
    if (owner !== 2'd0) begin
      errors++;
      $display("FAIL lock_own0 got %0d exp 0", owner);
    end
    @(negedge clk);
    req[0] = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL lock_again got %b exp 0100", gnt);
    end
    @(negedge clk);
    req  = '0;
    lock = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_reset_mid();
`ifdef REGFL_ARB_LOCK_EN
    test_lock();
`endif
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
